// File: rtl/matrix_bank.sv
// Layered square matrix store: masked row writes, row/column reads with write-first
// forwarding, range checking and a one-row-per-cycle layer clear.

module matrix_bank_lane #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int max_layer = 36,
    parameter int LW        = 6,
    parameter int RW        = 2
) (
    input  logic                           i_clk,
    input  logic                           i_wr_en,
    input  logic [LW-1:0]                  i_wr_layer,
    input  logic [RW-1:0]                  i_wr_row,
    input  logic [data_size-1:0]           i_wr_data,
    input  logic                           i_clr_en,
    input  logic [LW-1:0]                  i_clr_layer,
    input  logic [RW-1:0]                  i_clr_row,
    input  logic [LW-1:0]                  i_rd_layer,
    input  logic [RW-1:0]                  i_rd_row,
    output logic [data_size-1:0]           o_row_elem,
    output logic [size-1:0][data_size-1:0] o_col
);
    // One lane holds a single matrix column across all layers and rows.
    logic [data_size-1:0] r_mem [max_layer][size];

    // Clear first, write second: a same-row user write overrides the clear.
    always_ff @(posedge i_clk) begin
        if (i_clr_en) r_mem[i_clr_layer][i_clr_row] <= '0;
        if (i_wr_en)  r_mem[i_wr_layer][i_wr_row]   <= i_wr_data;
    end

    always_comb begin
        for (int r = 0; r < size; r++) begin
            o_col[r] = r_mem[i_rd_layer][r];
            if (i_clr_en && i_clr_layer == i_rd_layer && i_clr_row == RW'(r))
                o_col[r] = '0;
            if (i_wr_en && i_wr_layer == i_rd_layer && i_wr_row == RW'(r))
                o_col[r] = i_wr_data;
        end
    end

    assign o_row_elem = o_col[i_rd_row];
endmodule

module matrix_bank #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int max_layer = 36
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [data_size*size-1:0]   i_write_data,
    input  logic [31:0]                 i_write_layer_index,
    input  logic [31:0]                 i_write_row_index,
    input  logic [size-1:0]             i_write_mask,
    input  logic                        i_is_write,
    input  logic [31:0]                 i_read_layer_index,
    input  logic [31:0]                 i_read_index,
    input  logic                        i_read_transpose,
    input  logic                        i_is_read,
    output logic [data_size*size-1:0]   o_read_data,
    output logic                        o_read_valid,
    output logic                        o_read_error,
    output logic                        o_write_error,
    input  logic                        i_clear_start,
    input  logic [31:0]                 i_clear_layer_index,
    output logic                        o_clear_busy,
    output logic                        o_clear_done
);
    localparam int LW = (max_layer > 1) ? $clog2(max_layer) : 1;
    localparam int RW = $clog2(size);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    typedef struct packed {
        logic                           vld;
        logic                           err;
        logic [size-1:0][data_size-1:0] data;
    } rd_rsp_t;

    logic                                     w_wr_ok;
    logic                                     w_rd_ok;
    logic                                     w_clr_ok;
    logic                                     w_wr_en;
    logic                                     w_clr_en;
    logic [LW-1:0]                            w_wr_layer;
    logic [RW-1:0]                            w_wr_row;
    logic [LW-1:0]                            w_rd_layer;
    logic [RW-1:0]                            w_rd_idx;
    logic [size-1:0][data_size-1:0]           w_wr_elems;
    logic [size-1:0][data_size-1:0]           w_rd_row;
    logic [size-1:0][size-1:0][data_size-1:0] w_lane_col;
    logic [size-1:0][data_size-1:0]           w_rd_elems;

    rd_rsp_t       r_rsp;
    logic          r_wr_err;
    state_t        r_state;
    logic          r_clear_busy;
    logic          r_clear_done;
    logic [LW-1:0] r_clr_layer;
    logic [RW-1:0] r_clr_row;

    assign w_wr_ok  = (i_write_layer_index < 32'(max_layer)) && (i_write_row_index < 32'(size));
    assign w_rd_ok  = (i_read_layer_index  < 32'(max_layer)) && (i_read_index      < 32'(size));
    assign w_clr_ok = (i_clear_layer_index < 32'(max_layer));

    // Out-of-range indices are forced to zero so lanes never address past the arrays.
    assign w_wr_en    = i_is_write && w_wr_ok;
    assign w_wr_layer = w_wr_ok ? i_write_layer_index[LW-1:0] : '0;
    assign w_wr_row   = w_wr_ok ? i_write_row_index[RW-1:0]   : '0;
    assign w_rd_layer = w_rd_ok ? i_read_layer_index[LW-1:0]  : '0;
    assign w_rd_idx   = w_rd_ok ? i_read_index[RW-1:0]        : '0;
    assign w_clr_en   = (r_state == S_CLEAR) && i_rst_n;

    for (genvar c = 0; c < size; c++) begin : g_lane
        assign w_wr_elems[c] = i_write_data[(size-c)*data_size-1 -: data_size];

        matrix_bank_lane #(
            .size      (size),
            .data_size (data_size),
            .max_layer (max_layer),
            .LW        (LW),
            .RW        (RW)
        ) u_lane (
            .i_clk       (i_clk),
            .i_wr_en     (w_wr_en && i_write_mask[c]),
            .i_wr_layer  (w_wr_layer),
            .i_wr_row    (w_wr_row),
            .i_wr_data   (w_wr_elems[c]),
            .i_clr_en    (w_clr_en),
            .i_clr_layer (r_clr_layer),
            .i_clr_row   (r_clr_row),
            .i_rd_layer  (w_rd_layer),
            .i_rd_row    (w_rd_idx),
            .o_row_elem  (w_rd_row[c]),
            .o_col       (w_lane_col[c])
        );

        assign o_read_data[(size-c)*data_size-1 -: data_size] = r_rsp.data[c];
    end

    // Column read: element i of column k lives in lane k, row i.
    always_comb begin
        w_rd_elems = w_rd_row;
        if (i_read_transpose) w_rd_elems = w_lane_col[w_rd_idx];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_rsp.vld <= i_is_read;
            r_rsp.err <= i_is_read && !w_rd_ok;
            r_wr_err  <= i_is_write && !w_wr_ok;
            if (i_is_read) r_rsp.data <= w_rd_ok ? w_rd_elems : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_clr_layer  <= '0;
            r_clr_row    <= '0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_clear_start) begin
                        if (w_clr_ok) begin
                            r_clr_layer  <= i_clear_layer_index[LW-1:0];
                            r_clr_row    <= '0;
                            r_clear_busy <= 1'b1;
                            r_state      <= S_CLEAR;
                        end else begin
                            r_clear_done <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_clr_row == RW'(size-1)) begin
                        r_clear_busy <= 1'b0;
                        r_clear_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_clr_row <= r_clr_row + RW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_read_valid  = r_rsp.vld;
    assign o_read_error  = r_rsp.err;
    assign o_write_error = r_wr_err;
    assign o_clear_busy  = r_clear_busy;
    assign o_clear_done  = r_clear_done;
endmodule

// File: doc/matrix_bank.md
Name: matrix_bank

Overview:
- Multi-layer square matrix store for the neural data path; successor to the per-row weight store.
- Holds `max_layer` matrices of `size`×`size` fixed-point elements.
- Adds per-element write masks, row or column (transpose) reads, a registered read with valid flag, out-of-range detection, and a layer-clear state machine.
- Sits between the weight loader and the MAC array; one write port and one read port, usable in the same cycle.

Parameters:
- size, 3, matrix dimension (rows = columns); ≥2.
- data_size, 16, element width in bits (Q8.8 signed by convention, opaque to this block).
- max_layer, 36, number of matrices held; ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- write_data  in  data_size*size  row to write; element i at bits [(size-i)*data_size-1 -: data_size].
- write_layer_index  in  32  target layer.
- write_row_index  in  32  target row.
- write_mask  in  size  bit i=1 enables write of element i (bit 0 ↔ element 0).
- is_write  in  1  write strobe.
- read_layer_index  in  32  source layer.
- read_index  in  32  row index, or column index when read_transpose=1.
- read_transpose  in  1  0 = read row, 1 = read column.
- is_read  in  1  read strobe.
- read_data  out  data_size*size  read result, same element packing as write_data.
- read_valid  out  1  one-cycle pulse, read_data valid.
- read_error  out  1  one-cycle pulse with read_valid: read was out of range.
- write_error  out  1  one-cycle pulse: write was out of range (write dropped).
- clear_start  in  1  request zeroing of one layer.
- clear_layer_index  in  32  layer to clear.
- clear_busy  out  1  clear FSM active.
- clear_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
Reset
- rst_n=0 at an edge: read_data=0, read_valid=0, read_error=0, write_error=0, clear_busy=0, clear_done=0; FSM→IDLE.
- Storage is NOT reset; contents are undefined until written or cleared.
- Reset mid-clear aborts the clear: rows already zeroed stay zero, no clear_done.

Write
- Takes effect at the edge where is_write=1.
- Only elements with write_mask[i]=1 are updated.
- Out of range (write_layer_index ≥ max_layer or write_row_index ≥ size): nothing written; write_error=1 next cycle.

Read
- Latency 1: is_read sampled at edge N; read_data and read_valid valid after edge N, for one cycle.
- read_transpose=0: element i = M[layer][read_index][i].
- read_transpose=1: element i = M[layer][i][read_index].
- Without is_read: read_valid=0 and read_data holds its last value.
- Out of range (layer ≥ max_layer or index ≥ size): read_data=0, read_valid=1, read_error=1.

Forwarding (write-first)
- A read sees the result of any write and/or clear-row operation in the same cycle.
- Row mode: masked elements come from write_data when layer and row match.
- Column mode: element write_row_index comes from write_data[read_index] when layers match and write_mask[read_index]=1.
- A clear row hit returns zero, then any same-cycle write overlays it.

Clear FSM
- IDLE: clear_start=1 with clear_layer_index < max_layer → latch layer, row counter=0 → CLEAR.
  - clear_layer_index out of range: clear_done pulses next cycle, no storage change, stays IDLE.
- CLEAR: clear_busy=1; zero every element of row counter of the latched layer each cycle; counter+1.
  - After row size-1 → DONE.
- DONE: clear_done=1 for one cycle, clear_busy=0 → IDLE.
- clear_start is ignored while not in IDLE.
- Clear takes size+1 cycles from the clear_start edge to the clear_done pulse.
- Same cycle and same row as a user write: clear zeros first, then masked user elements are written (user data wins).
- User reads and writes proceed normally during CLEAR.

Test Plan:
1. Reset, then write layer 2 row 1 = {0x0100,0x0200,0x0300} with mask 3'b111; read row → next cycle read_data={0x0100,0x0200,0x0300}, read_valid=1, read_error=0.
2. Fill layer 0 with M[r][c]=16*r+c; transpose read index 2 → {0x0002,0x0012,0x0022}.
3. Mask 3'b010 write of {0xAAAA,0xBBBB,0xCCCC} to row holding {1,2,3}, plus a same-cycle read of that row → {1,0xBBBB,3} (forwarded); a later read returns the same.
4. Write with layer=36 (max_layer default) → write_error pulse, storage unchanged; read with read_index=3 → read_data=0, read_valid=1, read_error=1.
5. clear_start on layer 0 (pre-filled) → clear_busy high for 3 cycles, clear_done on the 4th cycle; all rows read back zero. A write to row 1 during the row-1 clear cycle persists.
6. Assert rst_n=0 during CLEAR row 1 → clear_busy=0 next cycle, no clear_done; row 0 reads zero, row 2 keeps its old data.
